// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: walks start/data/parity/stop bits at the oversample
// rate, drives the sampler timing and assembles the byte with parity and stop checks.
module uart_rx_frame_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic       sampled_bit,
    input  logic       data_sampled,
    output logic       data_sample_en,
    output logic [4:0] edge_cnt,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] bit_cnt_r;
    logic       par_en_r;
    logic       par_typ_r;

    logic       edge_last_s;
    logic       strobe_s;
    logic [4:0] edge_inc_s;

    // Parity mismatch of a received byte against its parity bit (odd selects odd parity).
    function automatic logic parity_err_f(input logic [7:0] data,
                                          input logic       par_bit,
                                          input logic       odd);
        return par_bit ^ (^data) ^ odd;
    endfunction

    // Bit-timing decode: last tick of the bit and the qualified mid-bit sampler strobe.
    always_comb begin
        edge_last_s = ({1'b0, edge_cnt} == (prescale - 6'd1)) || (edge_cnt == 5'd31);
        strobe_s    = data_sampled && ({1'b0, edge_cnt} == ((prescale >> 1) + 6'd1));
        edge_inc_s  = edge_cnt + 5'd1;
    end

    // Frame state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            bit_cnt_r      <= 4'd0;
            edge_cnt       <= 5'd0;
            data_sample_en <= 1'b0;
            p_data         <= 8'h00;
            data_valid     <= 1'b0;
            par_err        <= 1'b0;
            stp_err        <= 1'b0;
            par_en_r       <= 1'b0;
            par_typ_r      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    edge_cnt  <= 5'd0;
                    bit_cnt_r <= 4'd0;
                    if (rx_in == 1'b0) begin
                        state_r        <= START;
                        data_sample_en <= 1'b1;
                        par_en_r       <= par_en;
                        par_typ_r      <= par_typ;
                        par_err        <= 1'b0;
                        stp_err        <= 1'b0;
                    end else begin
                        data_sample_en <= 1'b0;
                    end
                end
                START: begin
                    // A high mid-bit sample means the falling edge was only a glitch.
                    if (strobe_s && sampled_bit) begin
                        state_r        <= IDLE;
                        edge_cnt       <= 5'd0;
                        bit_cnt_r      <= 4'd0;
                        data_sample_en <= 1'b0;
                    end else if (edge_last_s) begin
                        state_r   <= DATA;
                        edge_cnt  <= 5'd0;
                        bit_cnt_r <= 4'd0;
                    end else begin
                        edge_cnt <= edge_inc_s;
                    end
                end
                DATA: begin
                    if (strobe_s) begin
                        p_data <= {sampled_bit, p_data[7:1]};
                    end else begin
                        p_data <= p_data;
                    end
                    if (edge_last_s) begin
                        edge_cnt <= 5'd0;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        edge_cnt <= edge_inc_s;
                    end
                end
                PARITY: begin
                    if (strobe_s) begin
                        par_err <= parity_err_f(p_data, sampled_bit, par_typ_r);
                    end else begin
                        par_err <= par_err;
                    end
                    if (edge_last_s) begin
                        state_r   <= STOP;
                        edge_cnt  <= 5'd0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        edge_cnt <= edge_inc_s;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start bit is never missed.
                    if (strobe_s) begin
                        stp_err        <= ~sampled_bit;
                        data_valid     <= ~par_err & sampled_bit;
                        state_r        <= IDLE;
                        edge_cnt       <= 5'd0;
                        bit_cnt_r      <= 4'd0;
                        data_sample_en <= 1'b0;
                    end else if (edge_last_s) begin
                        edge_cnt  <= 5'd0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        edge_cnt <= edge_inc_s;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    edge_cnt       <= 5'd0;
                    bit_cnt_r      <= 4'd0;
                    data_sample_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: open-loop line and sampler stimulus with
// hand-computed expectations checked by immediate assertions.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       data_sampled;
    logic       data_sample_en;
    logic [4:0] edge_cnt;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         n_cmp = 0;
    int         n_err = 0;
    int         vcount = 0;
    logic [7:0] vdata = 8'h00;

    uart_rx_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rx_in          (rx_in),
        .prescale       (prescale),
        .par_en         (par_en),
        .par_typ        (par_typ),
        .sampled_bit    (sampled_bit),
        .data_sampled   (data_sampled),
        .data_sample_en (data_sample_en),
        .edge_cnt       (edge_cnt),
        .p_data         (p_data),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .stp_err        (stp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then record any data_valid pulse.
    task automatic tick();
        @(negedge clk);
        if (data_valid === 1'b1) begin
            vcount++;
            vdata = p_data;
        end
    endtask

    task automatic idle(input int n);
        rx_in        = 1'b1;
        data_sampled = 1'b0;
        sampled_bit  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one frame; line bit b spans cycles [b*ps, (b+1)*ps) and its strobe is
    // presented so the DUT sees it at edge_cnt = ps/2+1 of that bit.
    task automatic run_frame(input string tag, input int ps, input logic [7:0] data,
                             input logic par_bit, input logic stop_bit,
                             input logic [7:0] prev_exp, input int max_c,
                             input bit stale, input bit flip);
        int          mid;
        int          nbits;
        int          total;
        int          stop_c;
        int          b;
        logic [10:0] line;
        mid    = ps / 2 + 1;
        nbits  = par_en ? 11 : 10;
        line   = par_en ? {stop_bit, par_bit, data, 1'b0} : {1'b0, stop_bit, data, 1'b0};
        total  = nbits * ps;
        stop_c = 1 + (nbits - 1) * ps + mid;
        if (max_c < total) total = max_c;
        prescale = 6'(ps);
        vcount   = 0;
        for (int c = 0; c < total; c++) begin
            tick();
            if (c == ps) check({tag, "_hold"}, {24'd0, p_data}, {24'd0, prev_exp});
            if (c == ps + 3) begin
                check({tag, "_edge"}, {27'd0, edge_cnt}, 32'd2);
                check({tag, "_dse"}, {31'd0, data_sample_en}, 32'd1);
            end
            if (flip && c == 2 * ps) begin
                par_en  = ~par_en;
                par_typ = ~par_typ;
            end
            rx_in = (c > stop_c) ? 1'b1 : line[c / ps];
            b = (c >= 1) ? (c - 1) / ps : 0;
            if (c >= 1 && (c - 1) % ps == mid) begin
                data_sampled = 1'b1;
                sampled_bit  = line[b];
            end else if (stale && c >= 1 && (c - 1) % ps == mid - 2) begin
                data_sampled = 1'b1;
                sampled_bit  = ~line[b];
            end else begin
                data_sampled = 1'b0;
                sampled_bit  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        rx_in        = 1'b1;
        prescale     = 6'd8;
        par_en       = 1'b0;
        par_typ      = 1'b0;
        sampled_bit  = 1'b0;
        data_sampled = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdata", {24'd0, p_data}, 32'h00);
        check("rst_edge", {27'd0, edge_cnt}, 32'd0);
        check("rst_dse", {31'd0, data_sample_en}, 32'd0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_par", {31'd0, par_err}, 32'd0);
        check("rst_stp", {31'd0, stp_err}, 32'd0);
        rst = 1'b0;
        idle(4);

        // prescale 8, no parity, 0xA5
        run_frame("a5", 8, 8'hA5, 1'b0, 1'b1, 8'h00, 100000, 1'b0, 1'b0);
        idle(4);
        check("a5_cnt", vcount, 32'd1);
        check("a5_data", {24'd0, vdata}, 32'hA5);
        check("a5_par", {31'd0, par_err}, 32'd0);
        check("a5_stp", {31'd0, stp_err}, 32'd0);

        // start glitch: line low two cycles, mid-start sample reads high
        prescale = 6'd8;
        vcount   = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 3) check("gl_dse_start", {31'd0, data_sample_en}, 32'd1);
            rx_in        = (c < 2) ? 1'b0 : 1'b1;
            data_sampled = (c == 6) ? 1'b1 : 1'b0;
            sampled_bit  = 1'b1;
        end
        idle(2);
        check("gl_cnt", vcount, 32'd0);
        check("gl_dse", {31'd0, data_sample_en}, 32'd0);
        check("gl_edge", {27'd0, edge_cnt}, 32'd0);
        check("gl_par", {31'd0, par_err}, 32'd0);
        check("gl_stp", {31'd0, stp_err}, 32'd0);
        check("gl_pdata", {24'd0, p_data}, 32'hA5);

        // prescale 16, even parity, 0x3C with wrong parity bit 1
        par_en  = 1'b1;
        par_typ = 1'b0;
        run_frame("pe", 16, 8'h3C, 1'b1, 1'b1, 8'hA5, 100000, 1'b0, 1'b0);
        idle(4);
        check("pe_cnt", vcount, 32'd0);
        check("pe_par", {31'd0, par_err}, 32'd1);
        check("pe_stp", {31'd0, stp_err}, 32'd0);
        check("pe_pdata", {24'd0, p_data}, 32'h3C);

        // same frame with correct even parity bit 0
        run_frame("pok", 16, 8'h3C, 1'b0, 1'b1, 8'h3C, 100000, 1'b0, 1'b0);
        idle(4);
        check("pok_cnt", vcount, 32'd1);
        check("pok_data", {24'd0, vdata}, 32'h3C);
        check("pok_par", {31'd0, par_err}, 32'd0);

        // odd parity, config flipped mid-frame must not matter
        par_en  = 1'b1;
        par_typ = 1'b1;
        run_frame("odd", 16, 8'h3C, 1'b1, 1'b1, 8'h3C, 100000, 1'b0, 1'b1);
        idle(4);
        check("odd_cnt", vcount, 32'd1);
        check("odd_par", {31'd0, par_err}, 32'd0);

        // prescale 32, no parity, 0x81 with stop bit low
        par_en  = 1'b0;
        par_typ = 1'b0;
        run_frame("se", 32, 8'h81, 1'b0, 1'b0, 8'h3C, 100000, 1'b0, 1'b0);
        idle(4);
        check("se_cnt", vcount, 32'd0);
        check("se_stp", {31'd0, stp_err}, 32'd1);
        check("se_par", {31'd0, par_err}, 32'd0);
        check("se_pdata", {24'd0, p_data}, 32'h81);

        // back-to-back 0x55 then 0xF0, the second with stale sampler strobes
        run_frame("b1", 8, 8'h55, 1'b0, 1'b1, 8'h81, 100000, 1'b0, 1'b0);
        check("b1_cnt", vcount, 32'd1);
        check("b1_data", {24'd0, vdata}, 32'h55);
        check("b1_stp", {31'd0, stp_err}, 32'd0);
        run_frame("b2", 8, 8'hF0, 1'b0, 1'b1, 8'h55, 100000, 1'b1, 1'b0);
        idle(4);
        check("b2_cnt", vcount, 32'd1);
        check("b2_data", {24'd0, vdata}, 32'hF0);
        check("b2_pdata", {24'd0, p_data}, 32'hF0);

        // reset during data bit 4, then a clean 0x0F
        run_frame("rs", 8, 8'h0F, 1'b0, 1'b1, 8'hF0, 43, 1'b0, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        rx_in        = 1'b1;
        data_sampled = 1'b0;
        @(negedge clk);
        check("rs_pdata", {24'd0, p_data}, 32'h00);
        check("rs_edge", {27'd0, edge_cnt}, 32'd0);
        check("rs_dse", {31'd0, data_sample_en}, 32'd0);
        check("rs_dv", {31'd0, data_valid}, 32'd0);
        check("rs_par", {31'd0, par_err}, 32'd0);
        check("rs_stp", {31'd0, stp_err}, 32'd0);
        rst    = 1'b0;
        vcount = 0;
        idle(20);
        check("rs_nopulse", vcount, 32'd0);
        run_frame("f0f", 8, 8'h0F, 1'b0, 1'b1, 8'h00, 100000, 1'b0, 1'b0);
        idle(4);
        check("f0f_cnt", vcount, 32'd1);
        check("f0f_data", {24'd0, vdata}, 32'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single receive clock at oversample rate; all logic on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port rx_in, input, 1, serial line; idle high.
REQ-004 SHALL have port prescale, input, 6, oversample ratio; legal values 8, 16, 32; stable during a frame.
REQ-005 SHALL have port par_en, input, 1, parity bit present when 1.
REQ-006 SHALL have port par_typ, input, 1, 0 = even, 1 = odd.
REQ-007 SHALL have port sampled_bit, input, 1, majority-voted bit from the sampler.
REQ-008 SHALL have port data_sampled, input, 1, sampler strobe qualifying sampled_bit.
REQ-009 SHALL have port data_sample_en, output, 1, sampler enable; high in every non-IDLE state.
REQ-010 SHALL have port edge_cnt, output, 5, oversample tick within the current bit.
REQ-011 SHALL have port p_data, output, 8, received byte, LSB first on the line.
REQ-012 SHALL have port data_valid, output, 1, one-cycle pulse for an error-free frame.
REQ-013 SHALL have port par_err, output, 1, parity mismatch flag for the last frame.
REQ-014 SHALL have port stp_err, output, 1, stop-bit-low flag for the last frame.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: edge_cnt = 0, bit_cnt = 0, data_sample_en = 0; rx_in = 0 at cycle t -> START at t+1 with edge_cnt = 0.
REQ-017 Non-IDLE: edge_cnt SHALL increment each cycle and wrap from prescale-1 to 0; bit_cnt (internal, 4 bits) SHALL increment on each wrap.
REQ-018 Valid strobe SHALL be data_sampled = 1 AND edge_cnt = (prescale>>1)+1; data_sampled at any other edge_cnt (stale sampler strobe) SHALL be ignored.
REQ-019 par_en and par_typ SHALL be latched on IDLE->START; changes mid-frame SHALL have no effect.
REQ-020 START: valid strobe with sampled_bit = 1 SHALL abort to IDLE (glitch) without data_valid or flag change; otherwise at wrap -> DATA with bit_cnt = 0.
REQ-021 DATA: each valid strobe SHALL shift sampled_bit into p_data MSB, shifting right; after the 8th data-bit wrap -> PARITY if latched par_en, else STOP.
REQ-022 PARITY: on the valid strobe, par_err SHALL be set to sampled_bit XOR (^p_data) XOR latched par_typ; at wrap -> STOP.
REQ-023 STOP: on the valid strobe, stp_err SHALL be set to ~sampled_bit, and the next state SHALL be IDLE, without waiting for the bit end, to allow back-to-back frames.
REQ-024 data_valid SHALL pulse exactly 1 cycle, the cycle after the STOP valid strobe, iff par_err = 0 and stp_err = 0 for that frame.
REQ-025 p_data SHALL hold its value from frame completion until the next frame's first data-bit shift.
REQ-026 par_err and stp_err SHALL clear on IDLE->START and otherwise hold; par_err SHALL stay 0 when parity is disabled.
REQ-027 A new start bit detected in IDLE immediately after STOP SHALL be accepted with no lost cycles.

Reset
REQ-028 rst = 1 at a clk edge SHALL force IDLE, edge_cnt = 0, bit_cnt = 0, data_sample_en = 0, p_data = 0x00, data_valid = 0, par_err = 0, stp_err = 0, and clear the latched parity configuration.
REQ-029 rst asserted mid-frame SHALL abort the frame with no data_valid pulse; reception SHALL resume on the first falling rx_in after rst deasserts.

Verification
REQ-030 prescale = 8, par_en = 0, frame 0xA5 with stop = 1 -> data_valid pulse, p_data = 0xA5, par_err = 0, stp_err = 0.
REQ-031 prescale = 16, par_en = 1, par_typ = 0, 0x3C with parity bit 1 -> par_err = 1, no data_valid; the same frame with parity bit 0 -> data_valid, p_data = 0x3C.
REQ-032 prescale = 8, rx_in low for 2 cycles then high -> return to IDLE after the START strobe, no data_valid, flags unchanged.
REQ-033 prescale = 32, 0x81 with stop bit = 0 -> stp_err = 1, no data_valid, p_data = 0x81.
REQ-034 prescale = 8, back-to-back 0x55 then 0xF0 with no idle gap -> two data_valid pulses, p_data = 0x55 then 0xF0.
REQ-035 rst pulsed during DATA bit 4, then a clean 0x0F frame -> all outputs zero after reset, then a single data_valid with p_data = 0x0F.
